uart_tx_arb: RTL and testbench

Round-robin transmit arbiter that shares the single transmitter of `uart_top` among `NREQ` byte sources. It sits between the requesters and the `dintx`/`newdata`/`donetx` pins of `uart_top`, in the same `clk` domain. It latches one byte per grant and holds `newdata` long enough for the baud-rate transmitter to sample it. It then waits for frame completion and reports done, or a timeout error, back to the granted requester.

---
 rtl/uart_tx_arb.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin transmit arbiter sharing one uart_top transmitter among NREQ byte sources.
// Latches one byte per grant, holds newdata for two bit times, then waits for done or timeout.
module uart_tx_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CLK_FREQ = 1000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic [7:0]              dintx,
    output logic                    newdata,
    input  logic                    donetx,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
    localparam int unsigned HOLD_CYC = 2 * BIT_CYC;
    localparam int unsigned TMO_CYC  = 16 * BIT_CYC;
    localparam int unsigned CW       = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   owner_d;
    logic [7:0]      dintx_d;
    logic            newdata_d;
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] done_d;
    logic [NREQ-1:0] err_d;
    logic            busy_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            donetx_q;
    logic            donetx_rise;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;

    // First requester at or above ptr, wrapping modulo NREQ
    always_comb begin
        int unsigned j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!pick_found && req[IW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    assign donetx_rise = donetx & ~donetx_q;
    assign cnt_inc     = (cnt == CW'(TMO_CYC)) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        owner_d   = owner;
        dintx_d   = dintx;
        newdata_d = 1'b0;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = '0;
        cnt_d     = cnt_inc;

        case (state)
            IDLE: begin
                cnt_d = cnt;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    dintx_d         = req_data[{pick_idx, 3'b000} +: 8];
                    owner_d         = pick_idx;
                    ptr_d           = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    cnt_d           = '0;
                    newdata_d       = 1'b1;
                    state_d         = SEND;
                end
            end
            SEND: begin
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_d = WAIT;
                end else begin
                    newdata_d = 1'b1;
                end
            end
            WAIT: begin
                // A genuine completion wins over a timeout landing in the same cycle
                if (donetx_rise) begin
                    done_d[owner] = 1'b1;
                    state_d       = DRAIN;
                end else if (cnt >= CW'(TMO_CYC - 1)) begin
                    err_d[owner] = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (!donetx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            dintx    <= '0;
            newdata  <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            donetx_q <= 1'b0;
        end else begin
            ptr      <= ptr_d;
            owner    <= owner_d;
            dintx    <= dintx_d;
            newdata  <= newdata_d;
            gnt      <= gnt_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
            cnt      <= cnt_d;
            donetx_q <= donetx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized frames against a round-robin reference model.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int BIT  = 1000000 / 9600;
    localparam int HOLD = 2 * BIT;
    localparam int TMO  = 16 * BIT;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic [7:0]        dintx;
    logic              newdata;
    logic              donetx;
    logic              busy;
    logic [1:0]        owner;

    int n_total = 0;
    int n_pass  = 0;
    int mptr    = 0;

    uart_tx_arb #(.NREQ(NREQ), .CLK_FREQ(1000000), .BAUD(9600)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .dintx    (dintx),
        .newdata  (newdata),
        .donetx   (donetx),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference arbitration: first asserted request at or after the pointer, modulo NREQ
    function automatic int model_pick(input logic [NREQ-1:0] m, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    // One complete transaction starting from IDLE with req already set
    task automatic frame(input bit hold, input int delay, input int width,
                         input bit tmo, input bit stale, output int p);
        int         nd;
        bit         quiet;
        logic [7:0] b;
        p    = model_pick(req, mptr);
        b    = req_data[p*8 +: 8];
        mptr = (p + 1) % NREQ;
        tick();
        chk("gnt", 32'(gnt), 32'(1) << p);
        chk("dintx", 32'(dintx), 32'(b));
        chk("owner", 32'(owner), 32'(p));
        chk("busy_grant", 32'(busy), 32'(1));
        chk("newdata_rise", 32'(newdata), 32'(1));
        if (!hold) req[p] = 1'b0;
        nd    = 1;
        quiet = 1'b1;
        for (int k = 0; k < HOLD + 4 && newdata; k++) begin
            if (stale) donetx = (k >= 10 && k < 20);
            tick();
            if (newdata) nd++;
            quiet &= (gnt == 0 && done == 0 && err == 0 && busy && dintx == b);
        end
        donetx = 1'b0;
        chk("newdata_len", 32'(nd), 32'(HOLD));
        chk("send_quiet", 32'(quiet), 32'(1));
        if (!tmo) begin
            quiet = 1'b1;
            for (int k = 0; k < delay; k++) begin
                tick();
                quiet &= (done == 0 && err == 0 && busy && !newdata && gnt == 0);
            end
            chk("wait_quiet", 32'(quiet), 32'(1));
            donetx = 1'b1;
            tick();
            chk("done", 32'(done), 32'(1) << p);
            chk("no_err", 32'(err), 32'(0));
            quiet = 1'b1;
            for (int k = 0; k < width - 1; k++) begin
                tick();
                quiet &= (done == 0 && err == 0 && gnt == 0 && busy && dintx == b);
            end
            chk("drain_quiet", 32'(quiet), 32'(1));
            donetx = 1'b0;
        end else begin
            quiet = 1'b1;
            for (int k = 0; k < TMO - HOLD - 1; k++) begin
                tick();
                quiet &= (done == 0 && err == 0 && busy);
            end
            chk("tmo_quiet", 32'(quiet), 32'(1));
            tick();
            chk("err", 32'(err), 32'(1) << p);
            chk("no_done", 32'(done), 32'(0));
        end
        tick();
        chk("busy_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        int  p;
        bit  quiet;
        int  order [5] = '{0, 1, 2, 3, 0};

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        donetx   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_newdata", 32'(newdata), 32'(0));
        chk("rst_owner", 32'(owner), 32'(0));
        chk("rst_dintx", 32'(dintx), 32'(0));
        chk("rst_pulses", 32'({gnt, done, err}), 32'(0));
        rst = 1'b0;

        // Single request from requester 1
        req_data = 32'h00_00_A5_00;
        req      = 4'b0010;
        frame(1'b0, 300, 3, 1'b0, 1'b0, p);
        chk("single_owner", 32'(p), 32'(1));

        // Back to reset ptr, then all four held continuously
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mptr = 0;
        req_data = $urandom;
        req      = 4'hF;
        for (int k = 0; k < 5; k++) begin
            frame(1'b1, 100 + k, 2, 1'b0, 1'b0, p);
            chk("rr_order", 32'(p), 32'(order[k]));
        end

        // Pointer wrap after a grant to 3
        req = 4'b1000;
        frame(1'b0, 40, 1, 1'b0, 1'b0, p);
        req = 4'b1001;
        frame(1'b0, 40, 1, 1'b0, 1'b0, p);
        chk("wrap_first", 32'(p), 32'(0));
        frame(1'b0, 40, 1, 1'b0, 1'b0, p);
        chk("wrap_second", 32'(p), 32'(3));

        // Timeout with donetx stuck low
        req_data = $urandom;
        req      = 4'b0100;
        frame(1'b0, 0, 1, 1'b1, 1'b0, p);

        // Wide donetx with a second request pending, then stale edge in SEND
        req_data = $urandom;
        req      = 4'b0011;
        frame(1'b0, 50, BIT, 1'b0, 1'b0, p);
        frame(1'b0, 30, 1, 1'b0, 1'b1, p);

        // Reset 500 cycles into a frame
        req_data = $urandom;
        req      = 4'b0010;
        p        = model_pick(req, mptr);
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'(1) << p);
        req = '0;
        repeat (499) tick();
        rst = 1'b1;
        tick();
        chk("midrst_newdata", 32'(newdata), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_owner", 32'(owner), 32'(0));
        chk("midrst_pulses", 32'({gnt, done, err}), 32'(0));
        rst  = 1'b0;
        mptr = 0;
        quiet = 1'b1;
        for (int k = 0; k < TMO + 50; k++) begin
            tick();
            quiet &= (done == 0 && err == 0 && busy == 0 && gnt == 0);
        end
        chk("aborted_silent", 32'(quiet), 32'(1));
        req_data = $urandom;
        req      = 4'b0100;
        frame(1'b0, 60, 2, 1'b0, 1'b0, p);
        chk("rst_regrant", 32'(p), 32'(2));

        // Randomized frames; losing requesters stay pending
        for (int i = 0; i < 14; i++) begin
            req      = req | 4'($urandom_range(1, 15));
            req_data = $urandom;
            frame(1'b0, int'($urandom_range(0, 1200)), int'($urandom_range(1, 150)),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0), p);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
